// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: stage register/control taps in, stall/flush/forward out.
// master = pipeline side, slave = controller side.
interface pipe_hazard_ctrl_if;
  logic [4:0] RS1_ID, RS2_ID;
  logic [4:0] RS1_EX, RS2_EX;
  logic [4:0] RD_EX, RD_MEM, RD_WB;
  logic       RegWEn_EX, RegWEn_MEM, RegWEn_WB;
  logic [1:0] WBSel_EX;
  logic       PCsel_EX;
  logic       DMEM_req_MEM;
  logic       DMEM_ready;
  logic       stall_IF, stall_ID;
  logic       stall_EX, stall_MEM;
  logic       flush_ID, flush_EX;
  logic       bubble_WB;
  logic [1:0] FwdA_EX, FwdB_EX;
  logic       dmem_err;

  modport master (
    output RS1_ID, RS2_ID, RS1_EX, RS2_EX,
    output RD_EX, RD_MEM, RD_WB,
    output RegWEn_EX, RegWEn_MEM, RegWEn_WB,
    output WBSel_EX, PCsel_EX,
    output DMEM_req_MEM, DMEM_ready,
    input  stall_IF, stall_ID, stall_EX, stall_MEM,
    input  flush_ID, flush_EX, bubble_WB,
    input  FwdA_EX, FwdB_EX, dmem_err
  );

  modport slave (
    input  RS1_ID, RS2_ID, RS1_EX, RS2_EX,
    input  RD_EX, RD_MEM, RD_WB,
    input  RegWEn_EX, RegWEn_MEM, RegWEn_WB,
    input  WBSel_EX, PCsel_EX,
    input  DMEM_req_MEM, DMEM_ready,
    output stall_IF, stall_ID, stall_EX, stall_MEM,
    output flush_ID, flush_EX, bubble_WB,
    output FwdA_EX, FwdB_EX, dmem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage RV32I hazard/sequencing controller with DMEM wait timeout.
// Optional PIPE_PERF_CNT_EN adds saturating stall/flush/load-use counters.
module pipe_hazard_ctrl #(
  parameter int         MAX_WAIT   = 15,
  parameter logic [1:0] LOAD_WBSEL = 2'b01
) (
  input  logic clk,
  input  logic rst,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_ldu_cnt,
`endif
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       err, err_n;
  logic       lu, br, mw;
  logic       ldu_act;

  assign lu = (hz.WBSel_EX == LOAD_WBSEL) && hz.RegWEn_EX &&
              (hz.RD_EX != 5'd0) &&
              ((hz.RD_EX == hz.RS1_ID) || (hz.RD_EX == hz.RS2_ID));
  assign br = hz.PCsel_EX;
  assign mw = hz.DMEM_req_MEM && !hz.DMEM_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 8'd0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    err_n        = err;
    ldu_act      = 1'b0;
    hz.stall_IF  = 1'b0;
    hz.stall_ID  = 1'b0;
    hz.stall_EX  = 1'b0;
    hz.stall_MEM = 1'b0;
    hz.flush_ID  = 1'b0;
    hz.flush_EX  = 1'b0;
    hz.bubble_WB = 1'b0;
    hz.FwdA_EX   = 2'b00;
    hz.FwdB_EX   = 2'b00;
    hz.dmem_err  = 1'b0;
    if (!rst) begin
      hz.dmem_err = err;
      if (hz.RegWEn_MEM && hz.RD_MEM != 5'd0 && hz.RD_MEM == hz.RS1_EX)
        hz.FwdA_EX = 2'b10;
      else if (hz.RegWEn_WB && hz.RD_WB != 5'd0 && hz.RD_WB == hz.RS1_EX)
        hz.FwdA_EX = 2'b01;
      if (hz.RegWEn_MEM && hz.RD_MEM != 5'd0 && hz.RD_MEM == hz.RS2_EX)
        hz.FwdB_EX = 2'b10;
      else if (hz.RegWEn_WB && hz.RD_WB != 5'd0 && hz.RD_WB == hz.RS2_EX)
        hz.FwdB_EX = 2'b01;
      unique case (state)
        RUN: begin
          if (mw) begin
            {hz.stall_IF, hz.stall_ID} = 2'b11;
            {hz.stall_EX, hz.stall_MEM} = 2'b11;
            hz.bubble_WB = 1'b1;
            state_n = MEM_WAIT;
            cnt_n = 8'd1;
          end else if (br) begin
            {hz.flush_ID, hz.flush_EX} = 2'b11;
          end else if (lu) begin
            {hz.stall_IF, hz.stall_ID} = 2'b11;
            hz.flush_EX = 1'b1;
            ldu_act = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (hz.DMEM_ready) begin
            state_n = RUN;
            cnt_n = 8'd0;
            if (br) begin
              {hz.flush_ID, hz.flush_EX} = 2'b11;
            end else if (lu) begin
              {hz.stall_IF, hz.stall_ID} = 2'b11;
              hz.flush_EX = 1'b1;
              ldu_act = 1'b1;
            end
          end else if (cnt == 8'(MAX_WAIT)) begin
            // access abandoned: pipeline released, result dropped
            err_n = 1'b1;
            hz.bubble_WB = 1'b1;
            state_n = RUN;
            cnt_n = 8'd0;
          end else begin
            {hz.stall_IF, hz.stall_ID} = 2'b11;
            {hz.stall_EX, hz.stall_MEM} = 2'b11;
            hz.bubble_WB = 1'b1;
            cnt_n = cnt + 8'd1;
          end
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= 32'd0;
      perf_flush_cnt <= 32'd0;
      perf_ldu_cnt   <= 32'd0;
    end else begin
      if (hz.stall_IF && perf_stall_cyc != 32'hFFFFFFFF)
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (hz.flush_ID && perf_flush_cnt != 32'hFFFFFFFF)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (ldu_act && perf_ldu_cnt != 32'hFFFFFFFF)
        perf_ldu_cnt <= perf_ldu_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (MAX_WAIT=4).
// Outputs are sampled 1 time unit after the falling edge.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  logic [7:0] ov;
  logic [3:0] fv;

  pipe_hazard_ctrl_if hif ();

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] p_stall, p_flush, p_ldu;
`endif

  pipe_hazard_ctrl #(.MAX_WAIT(4), .LOAD_WBSEL(2'b01)) dut (
    .clk(clk),
    .rst(rst),
`ifdef PIPE_PERF_CNT_EN
    .perf_stall_cyc(p_stall),
    .perf_flush_cnt(p_flush),
    .perf_ldu_cnt(p_ldu),
`endif
    .hz(hif.slave)
  );

  always #5 clk = ~clk;

  assign ov = {hif.stall_IF, hif.stall_ID, hif.stall_EX, hif.stall_MEM,
               hif.flush_ID, hif.flush_EX, hif.bubble_WB, hif.dmem_err};
  assign fv = {hif.FwdA_EX, hif.FwdB_EX};

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic clr();
    hif.RS1_ID = 0; hif.RS2_ID = 0;
    hif.RS1_EX = 0; hif.RS2_EX = 0;
    hif.RD_EX = 0; hif.RD_MEM = 0; hif.RD_WB = 0;
    hif.RegWEn_EX = 0; hif.RegWEn_MEM = 0; hif.RegWEn_WB = 0;
    hif.WBSel_EX = 0; hif.PCsel_EX = 0;
    hif.DMEM_req_MEM = 0; hif.DMEM_ready = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    hif.WBSel_EX = 2'b01; hif.RegWEn_EX = 1; hif.RD_EX = rd;
    hif.RS1_ID = 5'd5;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    set_lu(5'd5);
    hif.RD_MEM = 7; hif.RegWEn_MEM = 1; hif.RS1_EX = 7;
    #2;
    check("rst_outs", 32'(ov), 32'h00);
    check("rst_fwd", 32'(fv), 32'h0);

    @(negedge clk); rst = 1'b0; clr(); set_lu(5'd5); #1;
    check("ldu_rs1", 32'(ov), 32'hC4);
    @(negedge clk); clr(); set_lu(5'd0); #1;
    check("ldu_x0", 32'(ov), 32'h00);
    @(negedge clk); clr(); set_lu(5'd5);
    hif.RS1_ID = 0; hif.RS2_ID = 5; #1;
    check("ldu_rs2", 32'(ov), 32'hC4);
    @(negedge clk); hif.WBSel_EX = 2'b00; #1;
    check("no_load", 32'(ov), 32'h00);
    @(negedge clk); clr(); set_lu(5'd5); hif.PCsel_EX = 1; #1;
    check("br_ldu", 32'(ov), 32'h0C);

    @(negedge clk); clr(); hif.DMEM_req_MEM = 1; #1;
    check("mw_entry", 32'(ov), 32'hF2);
    @(negedge clk); #1;
    check("mw_wait1", 32'(ov), 32'hF2);
    @(negedge clk); hif.PCsel_EX = 1; #1;
    check("mw_br_ign", 32'(ov), 32'hF2);
    @(negedge clk); hif.DMEM_ready = 1; #1;
    check("mw_ready_br", 32'(ov), 32'h0C);
    @(negedge clk); clr(); hif.PCsel_EX = 1; #1;
    check("mw_back_run", 32'(ov), 32'h0C);

    @(negedge clk); clr(); hif.DMEM_req_MEM = 1; #1;
    check("to_entry", 32'(ov), 32'hF2);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("to_wait%0d", i), 32'(ov), 32'hF2);
    end
    @(negedge clk); #1;
    check("to_release", 32'(ov), 32'h02);
    @(negedge clk); clr(); hif.DMEM_ready = 1; #1;
    check("to_err_set", 32'(ov), 32'h01);
    @(negedge clk); clr(); #1;
    check("to_err_hold", 32'(ov), 32'h01);
    @(negedge clk); hif.PCsel_EX = 1; #1;
    check("to_err_run", 32'(ov), 32'h0D);

    @(negedge clk); clr();
    hif.RD_MEM = 7; hif.RD_WB = 7; hif.RegWEn_MEM = 1; hif.RegWEn_WB = 1;
    hif.RS1_EX = 7; hif.RS2_EX = 7; #1;
    check("fwd_mem", 32'(fv), 32'hA);
    @(negedge clk); hif.RegWEn_MEM = 0; #1;
    check("fwd_wb", 32'(fv), 32'h5);
    @(negedge clk); hif.RegWEn_MEM = 1;
    hif.RD_MEM = 0; hif.RD_WB = 0; hif.RS1_EX = 0; hif.RS2_EX = 0; #1;
    check("fwd_x0", 32'(fv), 32'h0);
    @(negedge clk); hif.RD_MEM = 3; hif.RD_WB = 4;
    hif.RS1_EX = 3; hif.RS2_EX = 4; #1;
    check("fwd_mix", 32'(fv), 32'h9);

    @(negedge clk); hif.DMEM_req_MEM = 1; #1;
    check("ar_entry", 32'(ov), 32'hF3);
    check("fwd_in_wait", 32'(fv), 32'h9);
    @(negedge clk); #1;
    check("ar_wait", 32'(ov), 32'hF3);
    #2 rst = 1'b1; #1;
    check("ar_outs", 32'(ov), 32'h00);
    check("ar_fwd", 32'(fv), 32'h0);
`ifdef PIPE_PERF_CNT_EN
    check("perf_stall0", p_stall, 32'd0);
    check("perf_flush0", p_flush, 32'd0);
    check("perf_ldu0", p_ldu, 32'd0);
`endif
    @(negedge clk); rst = 1'b0; clr(); hif.PCsel_EX = 1; #1;
    check("ar_run", 32'(ov), 32'h0C);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Drives stall and flush enables for every pipeline register.
- Selects EX-stage operand forwarding.
- Holds the pipeline in a wait state while a data-memory access is outstanding, with a bounded timeout.
- Sits beside the pipeline registers and takes register addresses and control bits from the ID/EX/MEM/WB stages.

Parameters:
MAX_WAIT, 15, maximum consecutive cycles spent in MEM_WAIT before timeout (1..255).
LOAD_WBSEL, 2'b01, WBSel encoding that selects DMEM (identifies a load).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
RS1_ID, RS2_ID  input  5  source registers of the instruction in ID
RS1_EX, RS2_EX  input  5  source registers of the instruction in EX
RD_EX, RD_MEM, RD_WB  input  5  destination registers per stage
RegWEn_EX, RegWEn_MEM, RegWEn_WB  input  1  register write enable per stage
WBSel_EX  input  2  writeback select of the EX instruction
PCsel_EX  input  1  branch/jump taken, resolved in EX
DMEM_req_MEM  input  1  MEM-stage instruction accesses DMEM this cycle
DMEM_ready  input  1  DMEM completes the access this cycle
stall_IF, stall_ID  output  1  hold the PC and the IF/ID register
stall_EX, stall_MEM  output  1  hold the ID/EX and EX/MEM registers
flush_ID, flush_EX  output  1  load a bubble into IF/ID and ID/EX (synchronous clear)
bubble_WB  output  1  MEM/WB captures a bubble (RegWEn_WB=0)
FwdA_EX, FwdB_EX  output  2  operand select: 00 regfile, 10 EX/MEM ALU_o, 01 MEM/WB result
dmem_err  output  1  sticky timeout flag

Behaviour:
- FSM states: RUN and MEM_WAIT. State is held in flops. A wait counter (8 bit) and dmem_err are also flops.
- All other outputs are combinational (Mealy) from state and inputs.
- While rst=1: state=RUN, counter=0, dmem_err=0, and every output is forced to 0.
- Load-use (RUN only) is true when WBSel_EX==LOAD_WBSEL, RegWEn_EX=1, RD_EX!=0, and RD_EX matches RS1_ID or RS2_ID.
  - Response: stall_IF=stall_ID=1 and flush_EX=1 for exactly that cycle (1-cycle bubble).
- Branch (RUN only): PCsel_EX=1 -> flush_ID=flush_EX=1, no stalls. This is a 2-instruction penalty.
- Memory wait entry: in RUN, DMEM_req_MEM=1 and DMEM_ready=0.
  - The same cycle, drive stall_IF/ID/EX/MEM=1 and bubble_WB=1.
  - Next state is MEM_WAIT and counter=1.
- In MEM_WAIT:
  - Outputs are the same as on entry. All flush outputs are 0, and PCsel_EX and load-use are ignored.
  - DMEM_ready=1: outputs all stalls 0 and bubble_WB 0 that cycle (the access completes and advances), then next state is RUN and counter=0. Pending branch and load-use hazards are evaluated normally in that cycle.
  - Otherwise the counter increments. When the counter==MAX_WAIT and ready is still 0, set dmem_err=1 (sticky until rst), release the stalls that cycle, and return to RUN (the access is abandoned; bubble_WB stays 1).
- Priority in RUN: memory wait > branch > load-use.
  - Branch and load-use in the same cycle: branch wins, no stall.
  - Memory wait with branch: branch flush is deferred until the PCsel_EX cycle following the release, because EX is held.
- Forwarding is independent of state:
  - FwdA_EX=10 if RegWEn_MEM, RD_MEM!=0 and RD_MEM==RS1_EX.
  - Otherwise FwdA_EX=01 if RegWEn_WB, RD_WB!=0 and RD_WB==RS1_EX.
  - Otherwise FwdA_EX=00.
  - FwdB_EX uses the same rules with RS2_EX.
  - x0 is never forwarded. MEM beats WB on a double match.
- Reset mid-wait: returns to RUN immediately (asynchronous); the abandoned access is not flagged.

Optional Feature:
PIPE_PERF_CNT_EN: when defined, adds three 32-bit output ports:
- perf_stall_cyc: increments every cycle stall_IF=1.
- perf_flush_cnt: increments every cycle a branch flush occurs.
- perf_ldu_cnt: increments every cycle a load-use stall occurs.

The counters saturate at 32'hFFFFFFFF and clear on rst. When the macro is undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Load-use: WBSel_EX=01, RegWEn_EX=1, RD_EX=5, RS1_ID=5 -> stall_IF=stall_ID=flush_EX=1 for 1 cycle. Same stimulus with RD_EX=0 -> no stall.
- Branch plus load-use: PCsel_EX=1 while the load-use condition holds -> flush_ID=flush_EX=1, stall_IF=0.
- Memory wait: DMEM_req_MEM=1, DMEM_ready low for 3 cycles then high -> stalls and bubble_WB high for 3 cycles, low on the ready cycle, state back to RUN, dmem_err=0.
- Timeout: MAX_WAIT=4, DMEM_ready held 0 -> stalls release on the 4th wait cycle, dmem_err=1, and it stays 1 after later ready pulses until rst.
- Forwarding: RD_MEM=RD_WB=7, both RegWEn=1, RS1_EX=7, RS2_EX=7 -> FwdA=FwdB=10. Drop RegWEn_MEM -> 01. RS1_EX=0 with RD=0 -> 00.
- Asynchronous reset asserted mid-MEM_WAIT, between clock edges -> all outputs 0 immediately, state RUN after release. With PIPE_PERF_CNT_EN defined, all counters read 0.
